// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: walks a shared command ROM from a caller-selected base
// address and feeds each entry (byte, D/C, CS, post-delay, last flag) to the
// SPI byte shifter. Several sequences (init, loop, window, sleep-out, ...)
// can live in the same ROM, each terminated by its own last flag.
module lcd_cmd_sequencer #(
   parameter int DW       = 8,
   parameter int AW       = 6,
   parameter int DLY_W    = 8,
   parameter int TICK_DIV = 100000,
   parameter int GAP      = 8,
   parameter int EW       = DW + 3 + DLY_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [AW-1:0] i_base_addr,
   input  logic          i_abort,
   output logic          o_rom_rd,
   output logic [AW-1:0] o_rom_addr,
   input  logic [EW-1:0] i_rom_data,
   output logic          o_send,
   output logic [DW-1:0] o_data,
   output logic          o_dc,
   output logic          o_cs,
   input  logic          i_command_sent,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_error,
   output logic [AW:0]   o_count
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
   localparam logic [AW-1:0] ADDR_TOP  = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_SEND, S_GAP, S_DELAY, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [EW-1:0]    entry_q, entry_d;
   logic [AW:0]      count_q, count_d;
   logic             err_q, err_d;
   logic             abort_q, abort_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [DLY_W-1:0] dly_q, dly_d;

   // entry field views
   logic [DW-1:0]    ent_data;
   logic             ent_dc, ent_cs, ent_last;
   logic [DLY_W-1:0] ent_dly;

   assign ent_data = entry_q[DW-1:0];
   assign ent_dc   = entry_q[DW];
   assign ent_cs   = entry_q[DW+1];
   assign ent_last = entry_q[DW+2];
   assign ent_dly  = entry_q[EW-1:DW+3];

   // state and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         entry_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         tick_q  <= '0;
         gap_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         entry_q <= entry_d;
         count_q <= count_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         tick_q  <= tick_d;
         gap_q   <= gap_d;
         dly_q   <= dly_d;
      end
   end

   // next-state: sequencing, gap/delay timing, abort latch and end-of-ROM check
   always_comb begin
      logic abort_now;
      logic do_step;
      state_d   = state_q;
      addr_d    = addr_q;
      entry_d   = entry_q;
      count_d   = count_q;
      err_d     = err_q;
      abort_d   = abort_q;
      tick_d    = tick_q;
      gap_d     = gap_q;
      dly_d     = dly_q;
      do_step   = 1'b0;
      // a request arriving this cycle counts as well as one already latched
      abort_now = abort_q | i_abort;

      if (state_q != S_IDLE && i_abort) abort_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            // abort in the same cycle as start suppresses the start
            if (i_start && !i_abort) begin
               addr_d  = i_base_addr;
               count_d = '0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = abort_now ? S_IDLE : S_LOAD;
         S_LOAD: begin
            if (abort_now) state_d = S_IDLE;
            else begin
               entry_d = i_rom_data;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // the byte in flight always completes; abort is taken afterwards
            if (i_command_sent) begin
               count_d = count_q + (AW+1)'(1);
               gap_d   = '0;
               state_d = abort_now ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (abort_now) state_d = S_IDLE;
            else if (gap_q == GAP_LAST) begin
               if (ent_dly != '0) begin
                  tick_d  = '0;
                  dly_d   = ent_dly;
                  state_d = S_DELAY;
               end else do_step = 1'b1;
            end else gap_d = gap_q + GW'(1);
         end
         S_DELAY: begin
            // ms-tick prescaler cascaded into the per-entry delay down-counter
            if (abort_now) state_d = S_IDLE;
            else if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (dly_q == DLY_W'(1)) do_step = 1'b1;
               else dly_d = dly_q - DLY_W'(1);
            end else tick_d = tick_q + TW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (do_step) begin
         if (ent_last) state_d = S_DONE;
         else if (addr_q == ADDR_TOP) begin
            // ran off the top of the ROM without a terminator
            err_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_FETCH;
         end
      end

      if (state_d == S_IDLE) abort_d = 1'b0;
   end

   // outputs decoded from registered state and entry only
   always_comb begin
      o_rom_rd   = (state_q == S_FETCH);
      o_rom_addr = addr_q;
      o_send     = 1'b0;
      o_data     = '0;
      o_dc       = 1'b1;
      o_cs       = 1'b1;
      o_busy     = (state_q != S_IDLE);
      o_done     = (state_q == S_DONE);
      o_error    = err_q;
      o_count    = count_q;
      case (state_q)
         S_SEND: begin
            o_send = 1'b1;
            o_data = ent_data;
            o_dc   = ent_dc;
            o_cs   = ent_cs;
         end
         S_GAP: begin
            o_dc = ent_dc;
            o_cs = ent_cs;
         end
         S_DELAY: o_dc = ent_dc;
         default: ;
      endcase
   end

endmodule
